channel_interleaver2: RTL
=========================

Name: channel_interleaver2

Overview:
Merges two independent valid/ready sample streams (e.g. RX path A and RX path B) into one tagged stream plus a channel indicator. Sits directly upstream of the 2-way channelizer, whose data/valid/channel/ready inputs it drives. Uses round-robin arbitration and one registered output stage. Keeps per-channel transfer counters for debug readback.

Parameters:
width, 32, sample word width for all data ports
CNT_W, 16, width of each per-channel transfer counter

Ports:
clk_in  input  1  system clock; everything is sampled on the rising edge
rst_n  input  1  asynchronous active-low reset
in_data_1  input  width  channel 0 sample
in_valid_1  input  1  channel 0 sample valid
out_ready_1  output  1  channel 0 sample accepted this cycle
in_data_2  input  width  channel 1 sample
in_valid_2  input  1  channel 1 sample valid
out_ready_2  output  1  channel 1 sample accepted this cycle
out_data  output  width  merged sample (registered)
out_valid  output  1  merged sample valid (registered)
channel  output  1  source of out_data: 0 = input 1, 1 = input 2 (registered)
in_ready  input  1  downstream ready
cnt_1  output  CNT_W  count of words delivered downstream from channel 0
cnt_2  output  CNT_W  count of words delivered downstream from channel 1

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, channel=0, cnt_1=0, cnt_2=0, last_grant=1 (so channel 0 wins the first contention).
- Downstream transfer: out_valid && in_ready on the same rising edge.
- load_en = !out_valid || in_ready. The output register is loaded only when load_en=1; otherwise all outputs hold (stable while stalled).
- Grant, combinational, evaluated only when load_en=1:
  - only in_valid_1 -> grant 0
  - only in_valid_2 -> grant 1
  - both valid -> grant = !last_grant
  - neither valid -> no grant
- out_ready_1 = load_en && grant0. out_ready_2 = load_en && grant1. Never both asserted in the same cycle. Ready does not depend on the valid of the other input beyond the arbitration above.
- On a grant: next cycle out_data = selected input, channel = grant, out_valid = 1, last_grant = grant.
- No grant with load_en=1: out_valid goes to 0; out_data and channel hold.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 word/cycle when in_ready is held high.
- Back-to-back: a transfer and a new load occur on the same edge with no bubble.
- Counters: cnt_1 or cnt_2 increments on each downstream transfer, selected by the registered channel. Counters wrap modulo 2^CNT_W without saturating.
- Input sample stability under stall is the upstream source's responsibility; this block never drops or duplicates a word.
- Reset asserted mid-stream discards the held word; no transfer is reported for it.

Optional Feature:
Macro CHANNEL_INTERLEAVER2_STRICT_ALT_EN.
- Defined: strict alternation for I/Q pairing. Grant is only ever !last_grant. If that channel is not valid, no grant is issued, even when the other channel is valid. The first grant after reset is channel 0.
- Undefined: work-conserving round-robin as described in Behaviour.

Decomposition:
- Shared package chan_pkg: CH_0=1'b0 and CH_1=1'b1 channel ID constants, and the default CNT_W constant.
- One natural sub-module, rr_arbiter2: holds last_grant, takes req[1:0], en and strict-mode select, and produces grant[1:0].
- The output register and counters stay in the top module.

Test Plan:
- Only channel 0 valid, in_ready=1, data 0xA0..0xA3 -> out_data 0xA0..0xA3 on consecutive cycles, channel=0, cnt_1=4, cnt_2=0.
- Both valid continuously, in_ready=1 -> channel sequence 0,1,0,1 starting with channel 0; out_ready_1/out_ready_2 strictly alternate.
- out_valid=1 and in_ready held 0 for 3 cycles -> out_data/channel/out_valid stable; out_ready_1=out_ready_2=0; counters unchanged.
- cnt_1 preloaded to 0xFFFF by 65535 transfers, then one more channel 0 transfer -> cnt_1 = 0x0000.
- STRICT_ALT_EN defined, only channel 0 valid -> exactly one channel 0 word out, then no further grants until in_valid_2=1; then channel 1 is delivered.
- rst_n pulsed low while out_valid=1 -> outputs zero immediately (asynchronously); after release the first contention grants channel 0.

Source files
------------

// File: rtl/chan_pkg.sv
// Shared constants for the two-channel interleaver: channel IDs and the
// default width of the per-channel transfer counters.
package chan_pkg;

    localparam logic CH_0          = 1'b0;
    localparam logic CH_1          = 1'b1;
    localparam int   CNT_W_DEFAULT = 16;

endpackage : chan_pkg

// File: rtl/channel_interleaver2_rr_arbiter2.sv
// Two-way arbiter with a remembered last grant.
// - Work-conserving mode: a lone requester always wins, and contention goes
//   to the channel that did not win last time.
// - Strict mode: only the channel opposite the last grant may win, even if
//   the other channel is the only one requesting.
// The grant output is combinational and is qualified by en. last_grant
// resets to CH_1, so channel 0 is preferred first in both modes.
module rr_arbiter2
    import chan_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    input  logic       strict_en,
    output logic [1:0] grant
);

    logic       last_grant_q;
    logic       last_grant_d;
    logic       pref_s;
    logic [1:0] grant_s;

    // Choose the winning channel from the requests and the preferred channel.
    always_comb begin
        pref_s  = ~last_grant_q;
        grant_s = 2'b00;
        if (!en) begin
            grant_s = 2'b00;
        end else if (strict_en) begin
            if (req[pref_s]) begin
                grant_s[pref_s] = 1'b1;
            end else begin
                grant_s = 2'b00;
            end
        end else begin
            case (req)
                2'b01:   grant_s = 2'b01;
                2'b10:   grant_s = 2'b10;
                2'b11:   grant_s[pref_s] = 1'b1;
                default: grant_s = 2'b00;
            endcase
        end
    end

    // Remember the most recent winner; hold it when nothing is granted.
    always_comb begin
        if (grant_s[0]) begin
            last_grant_d = CH_0;
        end else if (grant_s[1]) begin
            last_grant_d = CH_1;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // last_grant register.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= CH_1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign grant = grant_s;

endmodule : rr_arbiter2

// File: rtl/channel_interleaver2.sv
// Merges two valid/ready sample streams into one registered, channel-tagged
// stream, and keeps per-channel counters of the words delivered downstream.
// Optional build macro CHANNEL_INTERLEAVER2_STRICT_ALT_EN selects strict
// channel alternation (for I/Q pairing) instead of work-conserving
// round-robin arbitration.
module channel_interleaver2
    import chan_pkg::*;
#(
    parameter int width = 32,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic [width-1:0] in_data_1,
    input  logic             in_valid_1,
    output logic             out_ready_1,
    input  logic [width-1:0] in_data_2,
    input  logic             in_valid_2,
    output logic             out_ready_2,
    output logic [width-1:0] out_data,
    output logic             out_valid,
    output logic             channel,
    input  logic             in_ready,
    output logic [CNT_W-1:0] cnt_1,
    output logic [CNT_W-1:0] cnt_2
);

`ifdef CHANNEL_INTERLEAVER2_STRICT_ALT_EN
    localparam logic STRICT_ALT = 1'b1;
`else
    localparam logic STRICT_ALT = 1'b0;
`endif

    logic [width-1:0] out_data_q;
    logic [width-1:0] out_data_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic             channel_q;
    logic             channel_d;
    logic [CNT_W-1:0] cnt_1_q;
    logic [CNT_W-1:0] cnt_1_d;
    logic [CNT_W-1:0] cnt_2_q;
    logic [CNT_W-1:0] cnt_2_d;
    logic             load_en_s;
    logic             xfer_s;
    logic [1:0]       grant_s;

    // The output stage may take a new word when it is empty or being drained.
    assign load_en_s = ~out_valid_q | in_ready;
    assign xfer_s    = out_valid_q & in_ready;

    rr_arbiter2 u_arb (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .req       ({in_valid_2, in_valid_1}),
        .en        (load_en_s),
        .strict_en (STRICT_ALT),
        .grant     (grant_s)
    );

    // The grant already includes load_en, so the two readies are exclusive.
    assign out_ready_1 = grant_s[0];
    assign out_ready_2 = grant_s[1];

    // Next output word: load the granted input, empty on no grant, or hold.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        channel_d   = channel_q;
        if (load_en_s) begin
            if (grant_s[0]) begin
                out_data_d  = in_data_1;
                out_valid_d = 1'b1;
                channel_d   = CH_0;
            end else if (grant_s[1]) begin
                out_data_d  = in_data_2;
                out_valid_d = 1'b1;
                channel_d   = CH_1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Count each downstream transfer against the channel of the word leaving.
    always_comb begin
        cnt_1_d = cnt_1_q;
        cnt_2_d = cnt_2_q;
        if (xfer_s) begin
            if (channel_q == CH_0) begin
                cnt_1_d = cnt_1_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_2_d = cnt_2_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_1_d = cnt_1_q;
        end
    end

    // Output stage and counter registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            channel_q   <= CH_0;
            cnt_1_q     <= '0;
            cnt_2_q     <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            channel_q   <= channel_d;
            cnt_1_q     <= cnt_1_d;
            cnt_2_q     <= cnt_2_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign channel   = channel_q;
    assign cnt_1     = cnt_1_q;
    assign cnt_2     = cnt_2_q;

endmodule : channel_interleaver2
